// File: rtl/des_pkg.sv
// des_pkg
//   Shared definitions for the iterative DES round controller and its
//   round datapath: controller state encoding, round count and the
//   per-round C/D rotate schedules for both directions.
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } des_ctrl_state_t;

    // Encrypt rotates left after PC-1.
    localparam logic [1:0] SHIFT_ENC [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt rotates right.  Round 0 uses the unrotated PC-1 halves
    // (K16 == K0), hence the leading zero.
    localparam logic [1:0] SHIFT_DEC [DES_ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_round_ctrl.sv
// des_round_ctrl
//   Sequencer for a one-round-per-step DES datapath.  Accepts a start
//   request in IDLE, then strobes load, 16 rounds of round_en (each round
//   lasting ROUND_CYCLES clocks) and final_en, and pulses done one cycle
//   after FINAL.  All outputs are decoded from registered state.
//
//   Parameter
//     ROUND_CYCLES  clocks per round, 1..4
//   Ports
//     sysclk_125mhz  clock, rising edge
//     rst            synchronous active-high reset
//     start          request, accepted in IDLE only
//     encrypt        1 = encrypt, 0 = decrypt, sampled on accept
//     abort          cancel the operation in flight (ignored in IDLE)
//     busy           high in LOAD, ROUND and FINAL
//     done           one-cycle pulse after FINAL
//     load           datapath loads IP(pt) and PC-1(key)
//     round_en       datapath executes one round
//     round_idx      current round 0..15
//     shift_amt      C/D rotate amount for this round
//     shift_dir      0 = rotate left, 1 = rotate right
//     final_en       datapath applies swap + FP, captures result
//
//   state | meaning
//   IDLE  | waiting for start; counters cleared
//   LOAD  | one cycle, datapath loads L/R and C/D
//   ROUND | 16 x ROUND_CYCLES cycles, round_en on last sub-cycle
//   FINAL | one cycle, result capture
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int ROUND_CYCLES = 1
) (
    input  logic       sysclk_125mhz,
    input  logic       rst,
    input  logic       start,
    input  logic       encrypt,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       load,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] shift_amt,
    output logic       shift_dir,
    output logic       final_en
);

    localparam int               SUB_W    = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ROUND_CYCLES - 1);
    localparam logic [3:0]       RND_LAST = 4'(DES_ROUNDS - 1);

    des_ctrl_state_t  state_q, state_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             sub_last;

    assign sub_last = (sub_q == SUB_LAST);

    always_ff @(posedge sysclk_125mhz) begin
        if (rst) begin
            state_q <= IDLE;
            sub_q   <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    mode_d  = encrypt;
                end
            end
            LOAD: state_d = ROUND;
            ROUND: begin
                if (sub_last) begin
                    sub_d = '0;
                    // round_idx stays at 15 through FINAL rather than wrapping
                    if (rnd_q == RND_LAST) state_d = FINAL;
                    else                   rnd_d   = rnd_q + 4'd1;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            FINAL: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Abort in FINAL still lets final_en fire this cycle, but done is dropped.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        if (state_d == IDLE) begin
            sub_d = '0;
            rnd_d = '0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign load      = (state_q == LOAD);
    assign round_en  = (state_q == ROUND) && sub_last;
    assign final_en  = (state_q == FINAL);
    assign done      = done_q;
    assign round_idx = rnd_q;
    assign shift_amt = busy ? (mode_q ? SHIFT_ENC[rnd_q] : SHIFT_DEC[rnd_q]) : 2'd0;
    assign shift_dir = busy & ~mode_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl.  Two instances (ROUND_CYCLES 1
// and 3) with independent stimulus; expected outputs come from a timeline
// model written from the cycle-offset rules of the controller.
module tb_des_round_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       load;
        logic       round_en;
        logic       final_en;
        logic [3:0] idx;
        logic [1:0] amt;
        logic       dir;
    } obs_t;

    localparam obs_t STROBE_MASK = 12'hF80;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       rst1, start1, enc1, abort1;
    logic       busy1, done1, load1, ren1, fen1, dir1;
    logic [3:0] idx1;
    logic [1:0] amt1;
    logic       rst3, start3, enc3, abort3;
    logic       busy3, done3, load3, ren3, fen3, dir3;
    logic [3:0] idx3;
    logic [1:0] amt3;

    des_round_ctrl #(.ROUND_CYCLES(1)) u_rc1 (
        .sysclk_125mhz(clk), .rst(rst1), .start(start1), .encrypt(enc1), .abort(abort1),
        .busy(busy1), .done(done1), .load(load1), .round_en(ren1), .round_idx(idx1),
        .shift_amt(amt1), .shift_dir(dir1), .final_en(fen1)
    );

    des_round_ctrl #(.ROUND_CYCLES(3)) u_rc3 (
        .sysclk_125mhz(clk), .rst(rst3), .start(start3), .encrypt(enc3), .abort(abort3),
        .busy(busy3), .done(done3), .load(load3), .round_en(ren3), .round_idx(idx3),
        .shift_amt(amt3), .shift_dir(dir3), .final_en(fen3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int ENC_SCHED [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int DEC_SCHED [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic int rc_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic obs_t get_obs(input int d);
        if (d == 0) return obs_t'({busy1, done1, load1, ren1, fen1, idx1, amt1, dir1});
        return obs_t'({busy3, done3, load3, ren3, fen3, idx3, amt3, dir3});
    endfunction

    task automatic drive(input int d, input logic s, input logic e, input logic a, input logic r);
        if (d == 0) begin
            start1 = s; enc1 = e; abort1 = a; rst1 = r;
        end else begin
            start3 = s; enc3 = e; abort3 = a; rst3 = r;
        end
    endtask

    // Expected outputs k cycles after the accept cycle (k = 0).
    function automatic obs_t model(input int rc, input bit enc, input int k);
        obs_t o;
        int   t_final;
        int   j;
        int   r;
        o = '0;
        t_final = 2 + 16 * rc;
        if (k == 1) begin
            o.busy = 1'b1; o.load = 1'b1;
        end else if (k >= 2 && k < t_final) begin
            j = k - 2;
            r = j / rc;
            o.busy     = 1'b1;
            o.round_en = ((j % rc) == rc - 1);
            o.idx      = 4'(r);
            o.amt      = 2'(enc ? ENC_SCHED[r] : DEC_SCHED[r]);
            o.dir      = !enc;
        end else if (k == t_final) begin
            o.busy = 1'b1; o.final_en = 1'b1;
        end else if (k == t_final + 1) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    // Round index and schedule are only defined while rounds run.
    function automatic obs_t mask_for(input int rc, input int k);
        if (k >= 2 && k < 2 + 16 * rc) return '1;
        return STROBE_MASK;
    endfunction

    // One operation on instance d.  kill_at > 0 applies abort (or reset when
    // kill_rst) during that cycle; hold keeps start high for a back-to-back
    // run; toggle flips encrypt every cycle after accept.
    task automatic run_op(input int d, input bit enc, input int kill_at, input bit kill_rst,
                          input bit hold, input bit toggle, input string name);
        int   rc;
        int   t_done;
        int   k_end;
        bit   cur_enc;
        bit   enc2;
        bit   killed;
        obs_t exp_o;
        obs_t got;
        obs_t mask;
        rc      = rc_of(d);
        t_done  = 3 + 16 * rc;
        k_end   = hold ? t_done + 2 : t_done + 3;
        cur_enc = enc;
        enc2    = enc;
        killed  = 1'b0;
        @(negedge clk);
        drive(d, 1'b1, enc, 1'b0, 1'b0);
        for (int k = 1; k <= k_end; k++) begin
            @(negedge clk);
            if (killed) begin
                exp_o = '0;
                mask  = (kill_rst && k == kill_at + 1) ? obs_t'('1) : STROBE_MASK;
            end else if (hold && k > t_done) begin
                exp_o = model(rc, enc2, k - t_done);
                mask  = mask_for(rc, k - t_done);
            end else begin
                exp_o = model(rc, enc, k);
                mask  = mask_for(rc, k);
            end
            got = get_obs(d);
            n_checks++;
            if ((got & mask) !== (exp_o & mask)) begin
                n_fail++;
                $display("FAIL %s rc%0d cycle %0d: got %h required %h (mask %h)",
                         name, rc, k, got, exp_o, mask);
            end
            if (toggle) cur_enc = ~cur_enc;
            if (k == t_done) enc2 = cur_enc;
            if (killed) begin
                drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                drive(d, hold, cur_enc, (k == kill_at) && !kill_rst, (k == kill_at) && kill_rst);
                if (k == kill_at) killed = 1'b1;
            end
        end
        if (hold) begin
            drive(d, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            got = get_obs(d);
            n_checks++;
            if (got !== obs_t'('0)) begin
                n_fail++;
                $display("FAIL reset_state rc%0d: got %h required %h", rc_of(d), got, obs_t'('0));
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_encrypt_rc1();
        run_op(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "encrypt_rc1");
    endtask

    task automatic test_decrypt_rc1();
        run_op(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "decrypt_rc1");
    endtask

    task automatic test_rc3();
        run_op(1, 1'b1, 0, 1'b0, 1'b0, 1'b0, "encrypt_rc3");
        run_op(1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "decrypt_rc3");
    endtask

    task automatic test_back_to_back();
        run_op(0, 1'b1, 0, 1'b0, 1'b1, 1'b1, "back_to_back_rc1");
        run_op(1, 1'b0, 0, 1'b0, 1'b1, 1'b1, "back_to_back_rc3");
    endtask

    task automatic test_abort();
        obs_t got;
        run_op(0, 1'b1, 7, 1'b0, 1'b0, 1'b0, "abort_round5");
        run_op(0, 1'b0, 18, 1'b0, 1'b0, 1'b0, "abort_final");
        run_op(1, 1'b1, 1, 1'b0, 1'b0, 1'b0, "abort_load");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
            got = get_obs(0);
            n_checks++;
            if ((got & STROBE_MASK) !== obs_t'('0)) begin
                n_fail++;
                $display("FAIL abort_start_idle cycle %0d: got %h required %h", k, got & STROBE_MASK, obs_t'('0));
            end
        end
    endtask

    task automatic test_reset_mid_round();
        run_op(0, 1'b1, 9, 1'b1, 1'b0, 1'b0, "reset_round7");
        run_op(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int  d;
        bit  enc;
        int  kill_at;
        for (int i = 0; i < 8; i++) begin
            d       = int'($urandom_range(0, 1));
            enc     = 1'($urandom_range(0, 1));
            kill_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 + 16 * rc_of(d))) : 0;
            run_op(d, enc, kill_at, 1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_encrypt_rc1();
        test_decrypt_rc1();
        test_rc3();
        test_back_to_back();
        test_abort();
        test_reset_mid_round();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencing controller for an iterative (one-round-per-step) DES datapath, replacing the fully unrolled combinational core behind the seven-segment display demo. It accepts a start request with an encrypt/decrypt select and drives the round datapath's load, round-enable, key-rotate and final-permutation strobes over 16 rounds. It then pulses `done` when the 64-bit result register is valid. It sits between the board-level control (buttons/switches) and the round datapath; the display mux reads the captured result.

## Interface
- `ROUND_CYCLES`, default 1: clock cycles per DES round (multicycle round datapath); legal 1..4.

- `sysclk_125mhz` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only in IDLE.
- `encrypt` in 1: 1 = encrypt, 0 = decrypt; sampled on the accept cycle only.
- `abort` in 1: cancel the operation in flight.
- `busy` out 1: high from LOAD through FINAL inclusive.
- `done` out 1: one-cycle pulse, result register valid.
- `load` out 1: datapath loads IP(plaintext) into L/R and PC-1(key) into C/D.
- `round_en` out 1: datapath executes one round and rotates C/D.
- `round_idx` out 4: current round, 0..15.
- `shift_amt` out 2: C/D rotate amount for this round (0, 1, or 2).
- `shift_dir` out 1: 0 = rotate left (encrypt), 1 = rotate right (decrypt).
- `final_en` out 1: datapath applies R16/L16 swap plus FP and captures the result register.

## Operation
- FSM states:
  - IDLE.
  - LOAD: 1 cycle.
  - ROUND: 16×`ROUND_CYCLES` cycles.
  - FINAL: 1 cycle.
- Transitions:
  - IDLE→LOAD on `start` & !`abort`.
  - LOAD→ROUND.
  - ROUND→FINAL after the last sub-cycle of round 15.
  - FINAL→IDLE.
- Sub-cycle counter (width `$clog2(ROUND_CYCLES)`, min 1) counts 0..`ROUND_CYCLES`-1 within each round.
  - `round_en` is high only on its last value.
  - `round_idx` increments after each `round_en` and holds across sub-cycles.
- Direction latch: `encrypt` is captured into a mode register on accept. `shift_dir` = !mode.
- Rotate schedule (`shift_amt`):
  - Encrypt, rounds 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, rounds 0..15: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- `shift_amt`/`shift_dir` are valid whenever `round_en` is high. They hold the current-round value otherwise.
- `done` is a registered one-cycle pulse asserted in the cycle after FINAL.
- `start` while busy is ignored; there is no queuing.
- A `start` in the `done` cycle is accepted (back-to-back operation).
- `abort` in any non-IDLE state:
  - Next state is IDLE.
  - All strobes are low from the next cycle.
  - No `done` is produced, and the result register is not updated.
- `abort` in IDLE is ignored. If `abort` and `start` are both high in IDLE, abort wins and the request is not accepted.
- `abort` in FINAL: `final_en` is already asserted that cycle (the capture happens), but `done` is suppressed.
- Reset (any state) gives IDLE with counters 0.
  - Outputs: `busy`, `done`, `load`, `round_en`, `final_en` = 0; `round_idx` = 0; `shift_amt` = 0; `shift_dir` = 0.

## Timing
- Accept is cycle 0 (IDLE, `start`=1).
- LOAD is cycle 1.
- With `ROUND_CYCLES`=1, `round_en` is high in cycles 2..17 with `round_idx` 0..15.
- FINAL is cycle 2+16×`ROUND_CYCLES`.
- `done` is cycle 3+16×`ROUND_CYCLES` (19 for RC=1, 51 for RC=3).
- Strobe outputs are Moore-decoded from registered state and counters, so there is no combinational path from inputs to outputs.
- `start`, `encrypt` and `abort` must be synchronous to `sysclk_125mhz`. The button synchronizer/debouncer lives outside this block.

## Structure
- `des_pkg`:
  - state enum `des_ctrl_state_t` {IDLE, LOAD, ROUND, FINAL}.
  - 16×2-bit constant arrays `SHIFT_ENC` and `SHIFT_DEC`.
  - constant `DES_ROUNDS` = 16.
- The round datapath uses the same package.
- One natural sub-module, `des_round_dp`: L/R and C/D registers, the f-function and PC-2, driven by this controller's strobes.
- The controller itself is a single module (FSM plus sub-cycle counter plus round counter).

## Test plan
- Reset: assert `rst` mid-ROUND at `round_idx`=7. Next cycle requires IDLE with `busy`=0 and every output 0. A new start afterwards runs normally from round 0.
- Encrypt, RC=1: `start`=1, `encrypt`=1 at c0. Required: `load` at c1; `round_en` at c2..c17 with `round_idx` 0..15, `shift_amt` 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, `shift_dir`=0; `final_en` at c18; `done` at c19. With `des_round_dp`, key 133457799BBCDFF1 and plaintext 0123456789ABCDEF must give result 85E813540F0AB405.
- Decrypt, RC=1: `encrypt`=0. Required: `shift_amt` 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, `shift_dir`=1. With the datapath, 85E813540F0AB405 must decrypt to 0123456789ABCDEF.
- RC=3: `round_en` is high every third cycle (c4, c7, …, c49), `final_en` at c50, `done` at c51, and `round_idx` is stable across sub-cycles.
- Handshake: hold `start` high throughout. Start is ignored while busy and re-accepted in the `done` cycle, with `load` in the following cycle. Toggle `encrypt` mid-operation: the schedule must not change.
- Abort: `abort` at `round_idx`=5 gives IDLE next cycle and no `done` ever. `abort`+`start` together in IDLE gives no `load`.
